// File: rtl/player_draw_ctrl_if.sv
// VGA write-port bundle shared between the player draw controller and the
// VGA arbiter/adapter. The controller is the master: it requests the port
// and presents pixel writes; the arbiter answers with a grant.
interface player_draw_ctrl_if;
  logic       vga_req;
  logic       vga_gnt;
  logic       plot;
  logic [2:0] colour;
  logic       add_x;
  logic [1:0] add_y;

  modport master (
    output vga_req,
    output plot,
    output colour,
    output add_x,
    output add_y,
    input  vga_gnt
  );

  modport slave (
    input  vga_req,
    input  plot,
    input  colour,
    input  add_x,
    input  add_y,
    output vga_gnt
  );
endinterface

// File: rtl/player_draw_ctrl.sv
// Per-frame sequencer for the player ship: erase at the old position, apply
// at most one clamped vertical move, wait for the datapath to settle, then
// redraw. The ship's y coordinate is tracked here so moves can be clamped.
module player_draw_ctrl #(
  parameter logic [7:0] Y_MIN         = 8'd0,
  parameter logic [7:0] Y_MAX         = 8'd116,
  parameter logic [7:0] Y_RESET       = 8'd0,
  parameter int         SETTLE_CYCLES = 2,
  parameter logic [2:0] BG_COLOUR     = 3'b000,
  parameter logic [2:0] SHIP_COLOUR   = 3'b010
) (
  input  logic                  clk,
  input  logic                  reset_n,    // active-high synchronous reset
  input  logic                  frame_tick,
  input  logic                  move_pos,
  input  logic                  move_neg,
  player_draw_ctrl_if.master    vga,
  output logic                  y_pos_mod,
  output logic                  y_neg_mod,
  output logic [7:0]            y_cur,
  output logic                  busy,
  output logic                  done,
  output logic                  overrun
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ERASE,
    S_MOVE,
    S_SETTLE,
    S_DRAW,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       y_q, y_d;
  logic             mv_pos_q, mv_pos_d;
  logic             mv_neg_q, mv_neg_d;
  logic             req_q, req_d;
  logic [2:0]       colour_q, colour_d;
  logic             y_pos_mod_q, y_pos_mod_d;
  logic             y_neg_mod_q, y_neg_mod_d;
  logic             done_q, done_d;
  logic             overrun_q, overrun_d;

  logic step_up;
  logic step_dn;

  // Move decision from the requests latched at the start of this update.
  assign step_up = mv_pos_q && !mv_neg_q && (y_q < Y_MAX);
  assign step_dn = mv_neg_q && !mv_pos_q && (y_q > Y_MIN);

  // Next-state and registered-output computation for the update sequence.
  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned; an unassigned path in always_comb would infer a latch.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    y_d         = y_q;
    mv_pos_d    = mv_pos_q;
    mv_neg_d    = mv_neg_q;
    req_d       = req_q;
    y_pos_mod_d = 1'b0;
    y_neg_mod_d = 1'b0;
    done_d      = 1'b0;
    overrun_d   = frame_tick && (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        if (frame_tick) begin
          mv_pos_d = move_pos;
          mv_neg_d = move_neg;
          req_d    = 1'b1;
          state_d  = S_ERASE;
        end
      end

      // A pixel is written only in cycles where the grant is present; the
      // index holds otherwise so a lost grant never skips or repeats a pixel.
      S_ERASE: begin
        if (vga.vga_gnt) begin
          idx_d = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            state_d     = S_MOVE;
            // The strobe is raised for exactly the MOVE cycle.
            y_pos_mod_d = step_up;
            y_neg_mod_d = step_dn;
            if (step_up) y_d = y_q + 8'd1;
            else if (step_dn) y_d = y_q - 8'd1;
          end
        end
      end

      S_MOVE: begin
        cnt_d   = '0;
        state_d = S_SETTLE;
      end

      // Always visited, even without a move, so update length depends only
      // on the grant pattern.
      S_SETTLE: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = S_DRAW;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_DRAW: begin
        if (vga.vga_gnt) begin
          idx_d = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            req_d   = 1'b0;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        req_d   = 1'b0;
      end
    endcase

    colour_d = 3'b000;
    if (state_d == S_ERASE) colour_d = BG_COLOUR;
    else if (state_d == S_DRAW) colour_d = SHIP_COLOUR;
  end

  // State and output registers with synchronous reset.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      state_q     <= S_IDLE;
      idx_q       <= 3'd0;
      cnt_q       <= '0;
      y_q         <= Y_RESET;
      mv_pos_q    <= 1'b0;
      mv_neg_q    <= 1'b0;
      req_q       <= 1'b0;
      colour_q    <= 3'b000;
      y_pos_mod_q <= 1'b0;
      y_neg_mod_q <= 1'b0;
      done_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      y_q         <= y_d;
      mv_pos_q    <= mv_pos_d;
      mv_neg_q    <= mv_neg_d;
      req_q       <= req_d;
      colour_q    <= colour_d;
      y_pos_mod_q <= y_pos_mod_d;
      y_neg_mod_q <= y_neg_mod_d;
      done_q      <= done_d;
      overrun_q   <= overrun_d;
    end
  end

  // Pixel address and colour come straight from flops; plot is the
  // registered write phase qualified by the live grant so a write is never
  // presented while the port is not ours.
  assign vga.vga_req = req_q;
  assign vga.plot    = ((state_q == S_ERASE) || (state_q == S_DRAW)) && vga.vga_gnt;
  assign vga.colour  = colour_q;
  assign vga.add_x   = idx_q[0];
  assign vga.add_y   = idx_q[2:1];

  assign y_pos_mod = y_pos_mod_q;
  assign y_neg_mod = y_neg_mod_q;
  assign y_cur     = y_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_player_draw_ctrl.sv
// Self-checking bench for player_draw_ctrl: expected pixel writes are queued
// when an update is launched and popped as the DUT plots them.
module tb_player_draw_ctrl;

  localparam logic [2:0] BG   = 3'b000;
  localparam logic [2:0] SHIP = 3'b010;
  localparam int         YMAX = 116;

  logic       clk;
  logic       reset_n;
  logic       frame_tick;
  logic       move_pos;
  logic       move_neg;
  logic       y_pos_mod;
  logic       y_neg_mod;
  logic [7:0] y_cur;
  logic       busy;
  logic       done;
  logic       overrun;

  player_draw_ctrl_if vga ();

  player_draw_ctrl dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .frame_tick (frame_tick),
    .move_pos   (move_pos),
    .move_neg   (move_neg),
    .vga        (vga),
    .y_pos_mod  (y_pos_mod),
    .y_neg_mod  (y_neg_mod),
    .y_cur      (y_cur),
    .busy       (busy),
    .done       (done),
    .overrun    (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int ovr_cnt = 0;
  int y_model = 0;
  logic [5:0] exp_q[$];   // {colour, add_y, add_x}

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard consumer: every pixel write must match the next expected one.
  always @(negedge clk) begin
    if (vga.plot === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("sb_underflow", 32'd1, 32'd0);
      end else begin
        check("pixel", {26'd0, vga.colour, vga.add_y, vga.add_x}, {26'd0, exp_q.pop_front()});
      end
    end
    if (overrun === 1'b1) ovr_cnt++;
  end

  // One full update. drop_at/drop_len remove the grant after a given number
  // of erase plots; ovr_test pulses frame_tick in DRAW and in DONE; rst_at
  // asserts reset after that many plots.
  task automatic do_update(input logic mp, input logic mn, input int drop_at,
                           input int drop_len, input bit ovr_test, input int rst_at);
    int cyc, plots, ups, dns, dropped, ovr0;
    bit seen_done, tick_sent;
    logic exp_up, exp_dn;
    exp_up = mp && !mn && (y_model < YMAX);
    exp_dn = mn && !mp && (y_model > 0);
    for (int i = 0; i < 8; i++) exp_q.push_back({BG, 3'(i)});
    for (int i = 0; i < 8; i++) exp_q.push_back({SHIP, 3'(i)});
    cyc = 0; plots = 0; ups = 0; dns = 0; dropped = 0;
    seen_done = 1'b0; tick_sent = 1'b0; ovr0 = ovr_cnt;

    @(posedge clk); #1;
    frame_tick = 1'b1; move_pos = mp; move_neg = mn; vga.vga_gnt = 1'b1;
    @(posedge clk); #1;
    frame_tick = 1'b0; move_pos = ~mp; move_neg = ~mn;   // must be ignored

    while (!seen_done && cyc < 200) begin
      cyc++;
      @(negedge clk);
      if (cyc == 1) begin
        check("req_rise", {31'd0, vga.vga_req}, 32'd1);
        check("busy_set", {31'd0, busy}, 32'd1);
      end
      if (vga.vga_gnt == 1'b0) begin
        check("hold_plot", {31'd0, vga.plot}, 32'd0);
        check("hold_idx", {29'd0, vga.add_y, vga.add_x}, 32'(drop_at));
      end
      if (vga.plot === 1'b1) plots++;
      if (y_pos_mod === 1'b1) ups++;
      if (y_neg_mod === 1'b1) dns++;
      if (done === 1'b1) begin
        seen_done = 1'b1;
        check("done_req_low", {31'd0, vga.vga_req}, 32'd0);
        if (ovr_test) frame_tick = 1'b1;   // tick during the DONE cycle
      end
      if (!seen_done) begin
        @(posedge clk); #1;
        frame_tick = 1'b0;
        if (rst_at >= 0 && plots == rst_at) begin
          check("y_before_rst", {24'd0, y_cur}, 32'(y_model));
          reset_n = 1'b1;
          @(posedge clk); #1;
          reset_n = 1'b0;
          @(negedge clk);
          check("rst_busy", {31'd0, busy}, 32'd0);
          check("rst_req", {31'd0, vga.vga_req}, 32'd0);
          check("rst_plot", {31'd0, vga.plot}, 32'd0);
          check("rst_y", {24'd0, y_cur}, 32'd0);
          exp_q.delete();
          y_model = 0;
          move_pos = 1'b0; move_neg = 1'b0;
          return;
        end
        if (ovr_test && plots == 11 && !tick_sent) begin
          frame_tick = 1'b1;
          tick_sent = 1'b1;
        end
        if (drop_at >= 0 && plots == drop_at && dropped < drop_len) begin
          vga.vga_gnt = 1'b0;
          dropped++;
        end else begin
          vga.vga_gnt = 1'b1;
        end
      end
    end

    check("done_seen", {31'd0, seen_done}, 32'd1);
    check("upd_len", 32'(cyc), 32'(20 + drop_len));
    check("plot_cnt", 32'(plots), 32'd16);
    check("up_strobes", 32'(ups), {31'd0, exp_up});
    check("dn_strobes", 32'(dns), {31'd0, exp_dn});
    if (exp_up) y_model++;
    if (exp_dn) y_model--;
    check("y_cur", {24'd0, y_cur}, 32'(y_model));

    @(posedge clk); #1;
    frame_tick = 1'b0; move_pos = 1'b0; move_neg = 1'b0;
    @(negedge clk);
    check("idle_busy", {31'd0, busy}, 32'd0);
    check("idle_req", {31'd0, vga.vga_req}, 32'd0);
    check("sb_empty", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    if (ovr_test) check("overrun_cnt", 32'(ovr_cnt - ovr0), 32'd2);
    check("still_idle", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    reset_n = 1'b1; frame_tick = 1'b0; move_pos = 1'b0; move_neg = 1'b0;
    vga.vga_gnt = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b0;
    @(negedge clk);
    check("rst0_busy", {31'd0, busy}, 32'd0);
    check("rst0_req", {31'd0, vga.vga_req}, 32'd0);
    check("rst0_plot", {31'd0, vga.plot}, 32'd0);
    check("rst0_done", {31'd0, done}, 32'd0);
    check("rst0_y", {24'd0, y_cur}, 32'd0);
    check("rst0_strobe", {30'd0, y_pos_mod, y_neg_mod}, 32'd0);

    do_update(1'b0, 1'b0, -1, 0, 1'b0, -1);        // plain update
    do_update(1'b0, 1'b1, -1, 0, 1'b0, -1);        // down at Y_MIN
    for (int i = 0; i < 3; i++) do_update(1'b1, 1'b0, -1, 0, 1'b0, -1);
    do_update(1'b1, 1'b0, 3, 5, 1'b0, -1);         // grant loss mid-erase
    for (int i = 0; i < 3; i++) do_update(1'b1, 1'b0, -1, 0, 1'b0, -1);
    do_update(1'b0, 1'b0, -1, 0, 1'b0, 11);        // reset mid-draw at y=7
    do_update(1'b0, 1'b0, -1, 0, 1'b1, -1);        // overrun in DRAW and DONE
    do_update(1'b0, 1'b0, -1, 0, 1'b0, -1);        // normal start afterwards
    for (int i = 0; i < YMAX; i++) do_update(1'b1, 1'b0, -1, 0, 1'b0, -1);
    do_update(1'b1, 1'b0, -1, 0, 1'b0, -1);        // up at Y_MAX
    do_update(1'b1, 1'b1, -1, 0, 1'b0, -1);        // both requested
    do_update(1'b0, 1'b1, -1, 0, 1'b0, -1);        // down from Y_MAX
    check("ovr_total", 32'(ovr_cnt), 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/player_draw_ctrl.md
Name: player_draw_ctrl

Overview:
Per-frame sequencer for the player ship datapath. On each frame tick it requests the shared VGA write port, erases the ship at its current position, and issues at most one clamped vertical move. It then waits for the datapath position to settle and redraws the ship. It drives the ship block's pixel-offset and move-strobe inputs and the VGA plot/colour lines, and tracks the ship's y coordinate itself so moves can be clamped.

Parameters:
Y_MIN, 0, lowest legal ship y (top-left pixel)
Y_MAX, 116, highest legal ship y (screen height 120 minus ship height 4)
Y_RESET, 0, ship y after reset; must equal the datapath reset value
SETTLE_CYCLES, 2, idle cycles after a move strobe before drawing (covers datapath register latency)
BG_COLOUR, 3'b000, erase colour
SHIP_COLOUR, 3'b010, draw colour

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous reset, active-high (1 = reset), sampled on posedge clk
frame_tick  in  1  one-cycle pulse per frame; starts an update
move_pos  in  1  request y+1 this frame
move_neg  in  1  request y-1 this frame
vga_gnt  in  1  VGA write port granted; plot is honoured only while high
vga_req  out  1  VGA write port request
plot  out  1  write one pixel this cycle
colour  out  3  pixel colour
add_x  out  1  x offset within ship (0..1)
add_y  out  2  y offset within ship (0..3)
y_pos_mod  out  1  one-cycle strobe: datapath y+1
y_neg_mod  out  1  one-cycle strobe: datapath y-1
y_cur  out  8  controller's tracked ship y
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse at end of update
overrun  out  1  one-cycle pulse when frame_tick arrives while busy

Behaviour:
- Reset (reset_n=1 at posedge): state=IDLE, y_cur=Y_RESET, pixel index=0, settle counter=0; all other outputs 0. Applies from any state and aborts an update in progress; vga_req drops the next cycle.
- add_x = idx[0], add_y = idx[2:1], where idx is a 3-bit pixel index. Order: (0,0),(1,0),(0,1),(1,1) ... (1,3).
- IDLE: outputs 0. On frame_tick, latch move_pos/move_neg, set vga_req=1, go to ERASE.
- ERASE: vga_req=1, colour=BG_COLOUR.
  - While vga_gnt=1: plot=1 and idx advances each cycle.
  - While vga_gnt=0: plot=0 and idx holds. Grant loss mid-sequence pauses without skipping or repeating a pixel.
  - After the plot with idx=7 is issued with gnt=1, idx wraps to 0 and the state moves to MOVE.
- MOVE (1 cycle): plot=0, vga_req stays 1.
  - Latched pos and not neg, with y_cur<Y_MAX: y_pos_mod=1, y_cur+1.
  - Latched neg and not pos, with y_cur>Y_MIN: y_neg_mod=1, y_cur-1.
  - Both, neither, or at a limit: no strobe, y_cur unchanged. y_cur never leaves [Y_MIN,Y_MAX].
  - Go to SETTLE.
- SETTLE: plot=0 for SETTLE_CYCLES cycles (counter), then go to DRAW. This state is entered even when no move occurred, so update length is constant for a given grant pattern.
- DRAW: identical to ERASE but with colour=SHIP_COLOUR. After idx=7 is plotted, go to DONE.
- DONE (1 cycle): done=1, vga_req=0, go to IDLE.
- Minimum update length with constant grant: 8+1+SETTLE_CYCLES+8+1 = 20 cycles at defaults.
- frame_tick while busy: ignored; overrun=1 that cycle. A tick in the DONE cycle counts as overrun. A tick in IDLE never does.
- move_pos/move_neg are sampled only on the IDLE→ERASE cycle; later changes have no effect on that update.
- Outputs are registered; plot, colour, add_x and add_y change together.

Test Plan:
- Reset, then frame_tick with no move and vga_gnt=1 → vga_req rises next cycle; 8 BG plots with offsets (0,0)..(1,3); no move strobe; 2 idle cycles; 8 SHIP_COLOUR plots; done pulses exactly 20 cycles after ERASE entry; y_cur=0.
- y_cur=0, frame_tick with move_neg=1 → no y_neg_mod, y_cur stays 0. Then 3 ticks with move_pos=1 → 3 single-cycle y_pos_mod strobes, y_cur=3.
- Drive y_cur to 116, then tick with move_pos=1 → no strobe, y_cur=116. move_pos and move_neg both 1 → no strobe.
- During ERASE, drop vga_gnt for 5 cycles after the 3rd plot → plot=0 and idx held at 3 for those cycles; on resume, plots continue from offset (1,1); total plots still 16; done delayed by 5 cycles.
- frame_tick pulsed in DRAW and again in DONE → overrun pulses twice; no second update starts; the next tick in IDLE starts normally.
- Assert reset_n mid-DRAW with y_cur=7 → next cycle state IDLE, vga_req=0, plot=0, y_cur=Y_RESET, busy=0.
